// File: rtl/tess_snes_pkg.sv
// tess_snes_pkg: shared SNES frame constants and poll FSM state type
package tess_snes_pkg;
  localparam int SNES_FRAME_BITS = 16;
  localparam int SNES_BTN_W = 12;
  localparam int IDX_W = $clog2(SNES_FRAME_BITS);
  typedef enum logic [2:0] {IDLE, LATCH, LOW, HIGH, DONE} snes_state_t;
endpackage

// File: rtl/snes_chan_capture.sv
// snes_chan_capture: per-controller shift, buttons and (SNES_STICKY_EN) sticky registers
module snes_chan_capture
  import tess_snes_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data,
  input  logic                  sample,
  input  logic [IDX_W-1:0]      index,
  input  logic                  load,
`ifdef SNES_STICKY_EN
  input  logic                  clear,
  output logic [SNES_BTN_W-1:0] sticky,
`endif
  output logic [SNES_BTN_W-1:0] buttons
);
  logic [SNES_BTN_W-1:0] shift;
  // keep only the button bits; the trailing frame bits are clocked past and dropped
  always_ff @(posedge clk or negedge rst)
    if (!rst) shift <= '0;
    else if (sample && index < IDX_W'(SNES_BTN_W)) shift[index] <= data;
  // the pad drives active-low, so invert once when publishing the frame
  always_ff @(posedge clk or negedge rst)
    if (!rst) buttons <= '0;
    else if (load) buttons <= ~shift;
`ifdef SNES_STICKY_EN
  // a read clears collected presses, but a press landing in the same cycle survives
  always_ff @(posedge clk or negedge rst)
    if (!rst) sticky <= '0;
    else sticky <= (clear ? '0 : sticky) | (load ? ~shift & ~buttons : '0);
`endif
endmodule

// File: rtl/snes_ctrlr_hub.sv
// snes_ctrlr_hub: polls NUM_CTRLRS SNES pads over one latch/pulse pair; SNES_STICKY_EN adds sticky press registers
module snes_ctrlr_hub
  import tess_snes_pkg::*;
#(
  parameter int NUM_CTRLRS = 2,
  parameter int CLK_DIV = 300,
  parameter int POLL_PERIOD = 833333,
  localparam int ADDR_W = (2 * NUM_CTRLRS > 2) ? $clog2(2 * NUM_CTRLRS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CTRLRS-1:0] snes_data,
  output logic                  snes_latch,
  output logic                  snes_pulse,
  input  logic                  poll_req,
  output logic                  poll_busy,
  output logic                  frame_done,
  input  logic                  read_enable,
  input  logic [ADDR_W-1:0]     address,
  output logic [SNES_BTN_W-1:0] read_data
);
  localparam int DW = $clog2(2 * CLK_DIV + 1);
  localparam int PMAX = POLL_PERIOD > 0 ? POLL_PERIOD - 1 : 0;
  localparam int PW = PMAX > 0 ? $clog2(PMAX + 1) : 1;

  snes_state_t state, nxt;
  logic [DW-1:0] dcnt;
  logic [PW-1:0] pcnt;
  logic [IDX_W-1:0] index;
  logic dend, tick, sample, load;
  logic [SNES_BTN_W-1:0] btn [NUM_CTRLRS];
`ifdef SNES_STICKY_EN
  logic [SNES_BTN_W-1:0] stk [NUM_CTRLRS];
`endif
  logic [SNES_BTN_W-1:0] rd;

  if (POLL_PERIOD > 0 && POLL_PERIOD < 34 * CLK_DIV + 2) begin : g_bad_period
    $error("POLL_PERIOD is shorter than one complete poll frame");
  end

  assign dend = dcnt == (state == LATCH ? DW'(2 * CLK_DIV - 1) : DW'(CLK_DIV - 1));
  assign tick = POLL_PERIOD != 0 && pcnt == PW'(PMAX);

  // free-running poll period counter, held at zero when only manual polls are used
  always_ff @(posedge clk or negedge rst)
    if (!rst) pcnt <= '0;
    else pcnt <= (POLL_PERIOD == 0 || tick) ? '0 : pcnt + 1'b1;

  // FSM state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;

  // phase divider restarts on every state change; bit index advances after each high phase
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dcnt <= '0;
      index <= '0;
    end else begin
      dcnt <= (state == IDLE || nxt != state) ? '0 : dcnt + 1'b1;
      index <= state == LATCH ? '0 : (state == HIGH && dend) ? index + 1'b1 : index;
    end

  // next-state: latch, then 16 low/high pulse pairs, then a single publish cycle
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = (tick || poll_req) ? LATCH : IDLE;
      LATCH: nxt = dend ? LOW : LATCH;
      LOW:   nxt = dend ? HIGH : LOW;
      HIGH:  nxt = dend ? (index == IDX_W'(SNES_FRAME_BITS - 1) ? DONE : LOW) : HIGH;
      default: nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the state; data is sampled at the end of each low phase
  always_comb begin
    snes_latch = state == LATCH;
    snes_pulse = state != LOW;
    poll_busy = state != IDLE;
    frame_done = state == DONE;
    sample = state == LOW && dend;
    load = state == DONE;
  end

  for (genvar c = 0; c < NUM_CTRLRS; c++) begin : g_chan
    snes_chan_capture u_chan (
      .clk(clk),
      .rst(rst),
      .data(snes_data[c]),
      .sample(sample),
      .index(index),
      .load(load),
`ifdef SNES_STICKY_EN
      .clear(read_enable && address == ADDR_W'(2 * c + 1)),
      .sticky(stk[c]),
`endif
      .buttons(btn[c])
    );
  end

  // register select; unmatched addresses (odd ones too without sticky) read zero
  always_comb begin
    rd = '0;
    for (int i = 0; i < NUM_CTRLRS; i++) begin
      if (address == ADDR_W'(2 * i)) rd = btn[i];
`ifdef SNES_STICKY_EN
      if (address == ADDR_W'(2 * i + 1)) rd = stk[i];
`endif
    end
  end

  // registered read port, zero whenever no read is requested
  always_ff @(posedge clk or negedge rst)
    if (!rst) read_data <= '0;
    else read_data <= read_enable ? rd : '0;
endmodule

// File: tb/tb_snes_ctrlr_hub.sv
// tb_snes_ctrlr_hub: randomized bench with a pad-level model for snes_ctrlr_hub (honours SNES_STICKY_EN)
module tb_snes_ctrlr_hub;
`ifdef SNES_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic [1:0] snes_data = 2'b11;
  logic snes_latch, snes_pulse, poll_req, poll_busy, frame_done, read_enable;
  logic [1:0] address;
  logic [11:0] read_data;
  logic latch0, pulse0, poll0, busy0, done0;
  logic [11:0] rd0;

  int n_tests = 0;
  int n_fail = 0;
  logic [15:0] press [2];
  logic [11:0] btn_m [2];
  logic [11:0] stk_m [2];
  bit rnd;
  bit last_fd;

  always #5 clk = ~clk;

  snes_ctrlr_hub #(.NUM_CTRLRS(2), .CLK_DIV(2), .POLL_PERIOD(200)) dut (
    .clk(clk), .rst(rst), .snes_data(snes_data), .snes_latch(snes_latch),
    .snes_pulse(snes_pulse), .poll_req(poll_req), .poll_busy(poll_busy),
    .frame_done(frame_done), .read_enable(read_enable), .address(address),
    .read_data(read_data)
  );

  snes_ctrlr_hub #(.NUM_CTRLRS(2), .CLK_DIV(2), .POLL_PERIOD(0)) dut0 (
    .clk(clk), .rst(rst), .snes_data(2'b11), .snes_latch(latch0),
    .snes_pulse(pulse0), .poll_req(poll0), .poll_busy(busy0),
    .frame_done(done0), .read_enable(1'b0), .address(2'b00),
    .read_data(rd0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] mread(input logic [1:0] a);
    return a[0] ? (STK ? stk_m[a[1]] : 12'h000) : btn_m[a[1]];
  endfunction

  // one clock: drive a read at a negedge, advance the model, check the result at the next negedge
  task automatic cyc(input bit re, input logic [1:0] a);
    logic [11:0] exp;
    bit fd;
    read_enable = re;
    address = a;
    exp = re ? mread(a) : 12'h000;
    fd = frame_done;
    if (re && a[0]) stk_m[a[1]] = 12'h000;
    if (fd)
      for (int ch = 0; ch < 2; ch++) begin
        stk_m[ch] = stk_m[ch] | (press[ch][11:0] & ~btn_m[ch]);
        btn_m[ch] = press[ch][11:0];
        if (rnd) press[ch] = 16'($urandom);
      end
    @(negedge clk);
    chk("read_data", 32'(read_data), 32'(exp));
    last_fd = fd;
  endtask

  task automatic rcyc();
    cyc($urandom_range(0, 2) == 0, 2'($urandom));
  endtask

  task automatic wait_frame(input bit rr);
    int n = 0;
    do begin
      if (rr) rcyc();
      else cyc(1'b0, 2'b00);
      n++;
    end while (!last_fd && n < 500);
    if (!last_fd) chk("frame_timeout", 32'(last_fd), 32'd1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!frame_done && n < 500) begin
      cyc(1'b0, 2'b00);
      n++;
    end
    chk("done_timeout", 32'(frame_done), 32'd1);
  endtask

  // pad model: latch reloads bit 0, each pulse rising edge presents the next bit; frame timing checked here
  int cnt, prev_rise, lows, falls, k;
  bit pl, pp;
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      cnt = 0;
      prev_rise = -1;
      lows = 0;
      falls = 0;
      k = 0;
      pl = 1'b0;
      pp = 1'b1;
    end else begin
      cnt++;
      if (snes_latch && !pl) begin
        if (prev_rise < 0) chk("first_latch", cnt, 200);
        else chk("poll_period", cnt - prev_rise, 200);
        prev_rise = cnt;
        lows = 0;
        falls = 0;
      end
      if (!snes_latch && pl) chk("latch_width", cnt - prev_rise, 4);
      if (!snes_pulse) lows++;
      if (!snes_pulse && pp) falls++;
      if (frame_done) begin
        chk("frame_len", cnt - prev_rise, 68);
        chk("low_cycles", lows, 32);
        chk("low_pulses", falls, 16);
        chk("busy_in_done", 32'(poll_busy), 32'd1);
      end
      if (snes_latch) k = 0;
      else if (snes_pulse && !pp) k++;
      pl = snes_latch;
      pp = snes_pulse;
    end
    for (int ch = 0; ch < 2; ch++) snes_data[ch] = (k < 16) ? ~press[ch][k] : 1'b0;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0, t;
    rst = 1'b0;
    read_enable = 1'b0;
    address = 2'b00;
    poll_req = 1'b0;
    poll0 = 1'b0;
    rnd = 1'b1;
    last_fd = 1'b0;
    for (int ch = 0; ch < 2; ch++) begin
      press[ch] = 16'($urandom);
      btn_m[ch] = 12'h000;
      stk_m[ch] = 12'h000;
    end
    repeat (3) @(negedge clk);
    chk("rst_latch", 32'(snes_latch), 32'd0);
    chk("rst_pulse", 32'(snes_pulse), 32'd1);
    chk("rst_busy", 32'(poll_busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_read", 32'(read_data), 32'd0);
    chk("rst_latch0", 32'(latch0), 32'd0);
    rst = 1'b1;

    l0 = 0;
    for (int i = 0; i < 1000; i++) begin
      rcyc();
      if (latch0 || !pulse0 || busy0) l0++;
    end
    chk("manual_idle", l0, 0);
    poll0 = 1'b1;
    rcyc();
    poll0 = 1'b0;
    chk("manual_latch_next", 32'(latch0), 32'd1);
    t = 0;
    repeat (10) begin
      rcyc();
      t++;
    end
    poll0 = 1'b1;
    rcyc();
    poll0 = 1'b0;
    t++;
    chk("manual_busy", 32'(busy0), 32'd1);
    while (!done0 && t < 200) begin
      rcyc();
      t++;
    end
    chk("manual_frame_len", t, 68);
    l0 = 0;
    repeat (100) begin
      rcyc();
      if (latch0) l0++;
    end
    chk("manual_poll_ignored", l0, 0);

    rnd = 1'b0;
    wait_frame(1'b0);
    press[0] = {4'($urandom), 12'h009};
    press[1] = {4'($urandom), 12'h800};
    wait_frame(1'b0);
    cyc(1'b1, 2'd0);
    chk("btn_ch0", 32'(read_data), 32'h009);
    cyc(1'b1, 2'd2);
    chk("btn_ch1", 32'(read_data), 32'h800);

    press[0] = 16'h0000;
    wait_frame(1'b0);
    cyc(1'b1, 2'd1);
    press[0] = 16'h0001;
    wait_frame(1'b0);
    press[0] = 16'h0000;
    wait_frame(1'b0);
    cyc(1'b1, 2'd1);
    chk("sticky_b", 32'(read_data), STK ? 32'h001 : 32'h000);
    cyc(1'b1, 2'd1);
    chk("sticky_cleared", 32'(read_data), 32'h000);

    press[1] = 16'h0000;
    wait_frame(1'b0);
    cyc(1'b1, 2'd3);
    press[1] = 16'h0004;
    wait_frame(1'b0);
    press[1] = 16'h0084;
    wait_done();
    cyc(1'b1, 2'd3);
    chk("sticky_in_done", 32'(read_data), STK ? 32'h004 : 32'h000);
    cyc(1'b0, 2'd0);
    cyc(1'b1, 2'd3);
    chk("sticky_survives", 32'(read_data), STK ? 32'h080 : 32'h000);

    rnd = 1'b1;
    repeat (20) wait_frame(1'b1);

    t = 0;
    while (!snes_latch && t < 400) begin
      rcyc();
      t++;
    end
    chk("latch_seen", 32'(snes_latch), 32'd1);
    repeat (30) cyc(1'b1, 2'd0);
    rst = 1'b0;
    #1;
    chk("midrst_latch", 32'(snes_latch), 32'd0);
    chk("midrst_pulse", 32'(snes_pulse), 32'd1);
    chk("midrst_read", 32'(read_data), 32'd0);
    chk("midrst_busy", 32'(poll_busy), 32'd0);
    for (int ch = 0; ch < 2; ch++) begin
      btn_m[ch] = 12'h000;
      stk_m[ch] = 12'h000;
    end
    repeat (3) cyc(1'b1, 2'($urandom));
    rst = 1'b1;
    repeat (3) wait_frame(1'b1);
    cyc(1'b1, 2'd0);
    cyc(1'b1, 2'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
